// File: rtl/ssd1306_spi4_rx.sv
// SSD1306 4-wire SPI receiver: oversampled byte assembly, command subset decode
// and conversion of display data into framebuffer write strobes.
module ssd1306_spi4_rx #(
    parameter int unsigned COLS        = 128,
    parameter int unsigned PAGES       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              spi_cs_n,
    input  logic                              spi_sck,
    input  logic                              spi_sdi,
    input  logic                              spi_dc,
    output logic                              byte_valid,
    output logic [7:0]                        byte_data,
    output logic                              byte_is_data,
    output logic                              fb_we,
    output logic [$clog2(COLS*PAGES)-1:0]     fb_addr,
    output logic [7:0]                        fb_wdata,
    output logic                              display_on,
    output logic [7:0]                        contrast
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned PW = $clog2(PAGES);
    localparam int unsigned AW = $clog2(COLS * PAGES);

    typedef enum logic [1:0] {IDLE, ARG1, ARG2} dec_state_t;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, sdi_sync, dc_sync;
    logic                   sck_prev;
    logic                   cs_s, sck_s, sdi_s, dc_s, sck_rise;
    logic [2:0]             bit_cnt;
    logic [6:0]             shift;
    logic                   byte_done;
    logic [7:0]             new_byte;

    dec_state_t             dec_state;
    logic [7:0]             cmd;
    logic [7:0]             arg1;
    logic [1:0]             mode;
    logic [CW-1:0]          col, col_start, col_end, pm_start, adv_col;
    logic [PW-1:0]          page, page_start, page_end, adv_page;
    logic                   unused_arg;

    // Sync flops reset to idle levels (CS deasserted, SCK high) so release never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync  <= '1;
            sck_sync <= '1;
            sdi_sync <= '0;
            dc_sync  <= '0;
            sck_prev <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0],  spi_cs_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            dc_sync  <= {dc_sync[SYNC_STAGES-2:0],  spi_dc};
            sck_prev <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev & ~cs_s;
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign new_byte  = {shift, sdi_s};
    assign fb_wdata  = byte_data;
    assign unused_arg = &{1'b0, arg1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (cs_s) begin
            bit_cnt <= '0;
        end else if (sck_rise) begin
            shift   <= {shift[5:0], sdi_s};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    function automatic logic [CW-1:0] inc_col(input logic [CW-1:0] c);
        return (32'(c) == COLS - 1) ? '0 : c + CW'(1);
    endfunction

    function automatic logic [PW-1:0] inc_page(input logic [PW-1:0] p);
        return (32'(p) == PAGES - 1) ? '0 : p + PW'(1);
    endfunction

    function automatic logic takes_one_arg(input logic [7:0] op);
        case (op)
            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    // Pointer position after a data byte, per addressing mode (mode 3 behaves as page)
    always_comb begin
        adv_col  = col;
        adv_page = page;
        if (mode[1]) begin
            adv_col = (32'(col) == COLS - 1) ? pm_start : inc_col(col);
        end else if (mode == 2'd0) begin
            if (col == col_end) begin
                adv_col  = col_start;
                adv_page = (page == page_end) ? page_start : inc_page(page);
            end else begin
                adv_col = inc_col(col);
            end
        end else begin
            if (page == page_end) begin
                adv_page = page_start;
                adv_col  = (col == col_end) ? col_start : inc_col(col);
            end else begin
                adv_page = inc_page(page);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            byte_is_data <= 1'b0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            display_on   <= 1'b0;
            contrast     <= 8'h7F;
            dec_state    <= IDLE;
            cmd          <= '0;
            arg1         <= '0;
            mode         <= 2'd2;
            col          <= '0;
            col_start    <= '0;
            col_end      <= CW'(COLS - 1);
            pm_start     <= '0;
            page         <= '0;
            page_start   <= '0;
            page_end     <= PW'(PAGES - 1);
        end else begin
            byte_valid <= 1'b0;
            fb_we      <= 1'b0;
            if (byte_done) begin
                byte_valid   <= 1'b1;
                byte_data    <= new_byte;
                byte_is_data <= dc_s;
                if (dc_s) begin
                    // Data also aborts any half-received command
                    fb_we     <= 1'b1;
                    fb_addr   <= AW'(32'(page) * COLS + 32'(col));
                    col       <= adv_col;
                    page      <= adv_page;
                    dec_state <= IDLE;
                end else begin
                    case (dec_state)
                        IDLE: begin
                            if (new_byte == 8'h21 || new_byte == 8'h22 ||
                                takes_one_arg(new_byte)) begin
                                cmd       <= new_byte;
                                dec_state <= ARG1;
                            end else if (new_byte == 8'hAE || new_byte == 8'hAF) begin
                                display_on <= new_byte[0];
                            end else if (mode[1]) begin
                                if (new_byte[7:4] == 4'h0) begin
                                    col      <= CW'((8'(col) & 8'hF0) | {4'h0, new_byte[3:0]});
                                    pm_start <= CW'((8'(col) & 8'hF0) | {4'h0, new_byte[3:0]});
                                end else if (new_byte[7:3] == 5'b00010) begin
                                    col      <= CW'((8'(col) & 8'h0F) | {1'b0, new_byte[2:0], 4'h0});
                                    pm_start <= CW'((8'(col) & 8'h0F) | {1'b0, new_byte[2:0], 4'h0});
                                end else if (new_byte[7:3] == 5'b10110) begin
                                    page <= PW'(new_byte[2:0]);
                                end
                            end
                        end
                        ARG1: begin
                            if (cmd == 8'h21 || cmd == 8'h22) begin
                                arg1      <= new_byte;
                                dec_state <= ARG2;
                            end else begin
                                if (cmd == 8'h20) mode     <= new_byte[1:0];
                                if (cmd == 8'h81) contrast <= new_byte;
                                dec_state <= IDLE;
                            end
                        end
                        ARG2: begin
                            if (cmd == 8'h21) begin
                                col_start <= CW'(arg1);
                                col_end   <= CW'(new_byte);
                                col       <= CW'(arg1);
                            end else begin
                                page_start <= PW'(arg1);
                                page_end   <= PW'(new_byte);
                                page       <= PW'(arg1);
                            end
                            dec_state <= IDLE;
                        end
                        default: dec_state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule
